// File: rtl/gcd_req_gen_pkg.sv
// Shared definitions for the GCD request generator: FSM encoding, LFSR
// polynomial and the default operand magnitude mask.
package gcd_req_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_POLY       = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_OP_MASK = 32'h0000_FFFF;

  // Right-shifting Galois step: the bit shifted out selects the feedback XOR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] swap_halves(input logic [31:0] s);
    return {s[15:0], s[31:16]};
  endfunction

endpackage

// File: rtl/gcd_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance enables; a zero seed
// is replaced by 1 so the register can never lock up in the all-zero state.
module gcd_lfsr32
  import gcd_req_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_adv,
  output logic [31:0] o_state
);

  logic [31:0] r_state;
  logic [31:0] w_seed_safe;

  assign w_seed_safe = (i_seed == 32'h0) ? 32'h1 : i_seed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= 32'h1;
    end else if (i_load) begin
      r_state <= w_seed_safe;
    end else if (i_adv) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/gcd_req_gen.sv
// Traffic generator for the GCD unit: issues LFSR operand pairs under an
// outstanding-request cap, retires results and accumulates a checksum.
module gcd_req_gen
  import gcd_req_gen_pkg::*;
#(
  parameter int          W       = 32,
  parameter int          CNT_W   = 16,
  parameter int          MAX_OUT = 2,
  parameter logic [31:0] OP_MASK = DEFAULT_OP_MASK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_reqs,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             operands_val,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  input  logic             operands_rdy,
  input  logic             result_val,
  input  logic [W-1:0]     result_bits_data,
  output logic             result_rdy,
  output logic [CNT_W-1:0] sent_count,
  output logic [CNT_W-1:0] recv_count,
  output logic [W-1:0]     checksum
);

  localparam int OUT_W = 8;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_recv;
  logic [OUT_W-1:0] r_outst;
  logic [W-1:0]     r_checksum;

  logic             w_start_ok;
  logic             w_load;
  logic             w_active;
  logic             w_op_val;
  logic             w_res_rdy;
  logic             w_op_fire;
  logic             w_res_fire;
  logic [CNT_W-1:0] w_sent_nxt;
  logic [CNT_W-1:0] w_recv_nxt;
  logic             w_sent_last;
  logic             w_recv_last;
  logic [31:0]      w_lfsr;
  logic [31:0]      w_mask_a;
  logic [31:0]      w_mask_b;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load     = w_start_ok && (num_reqs != '0);
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  // Issue qualification looks only at registered state so operands_val
  // never depends combinationally on operands_rdy.
  assign w_op_val   = (r_state == ST_RUN) && (r_sent < r_target) && (r_outst < MAX_OUT_C);
  assign w_res_rdy  = w_active && (r_outst != '0);
  assign w_op_fire  = w_op_val && operands_rdy;
  assign w_res_fire = w_res_rdy && result_val;

  assign w_sent_nxt  = r_sent + CNT_W'(w_op_fire);
  assign w_recv_nxt  = r_recv + CNT_W'(w_res_fire);
  assign w_sent_last = w_op_fire && (w_sent_nxt == r_target);
  assign w_recv_last = w_res_fire && (w_recv_nxt == r_target);

  gcd_lfsr32 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_seed  (seed),
    .i_adv   (w_op_fire),
    .o_state (w_lfsr)
  );

  assign w_mask_a = w_lfsr & OP_MASK;
  assign w_mask_b = swap_halves(w_lfsr) & OP_MASK;

  // Operand buses read zero whenever no pair is offered, so reset leaves
  // every output at 0 even though the LFSR itself resets to 1.
  assign operands_val    = w_op_val;
  assign operands_bits_A = w_op_val ? w_mask_a[W-1:0] : '0;
  assign operands_bits_B = w_op_val ? w_mask_b[W-1:0] : '0;
  assign result_rdy      = w_res_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_target   <= '0;
      r_sent     <= '0;
      r_recv     <= '0;
      r_outst    <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_target   <= num_reqs;
            r_sent     <= '0;
            r_recv     <= '0;
            r_outst    <= '0;
            r_checksum <= '0;
            if (num_reqs != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN, ST_DRAIN: begin
          r_sent <= w_sent_nxt;
          r_recv <= w_recv_nxt;
          if (w_res_fire) begin
            r_checksum <= r_checksum + result_bits_data;
          end
          // Simultaneous issue and retire leave the outstanding count alone.
          case ({w_op_fire, w_res_fire})
            2'b10:   r_outst <= r_outst + 1'b1;
            2'b01:   r_outst <= r_outst - 1'b1;
            default: r_outst <= r_outst;
          endcase
          if (w_recv_last && ((r_state == ST_DRAIN) || w_sent_last)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if ((r_state == ST_RUN) && w_sent_last) begin
            r_state <= ST_DRAIN;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign sent_count = r_sent;
  assign recv_count = r_recv;
  assign checksum   = r_checksum;

endmodule
